program_loader: RTL and testbench

Boot-time program loader and reset sequencer for the Hack CPU. It accepts a framed program image over a byte-wide valid/ready stream and writes it word-by-word into instruction ROM. It holds the CPU in reset for the whole load and releases it only after the image's checksum verifies. A later `load_req` re-enters loading and re-asserts CPU reset, so the host can reload without a board reset.

---
 rtl/program_loader_defs.sv | 16 +
 rtl/program_loader.sv | 125 ++++++++++++
 tb/tb_program_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_defs.sv
// Shared definitions for the Hack CPU boot-time program loader.
package program_loader_defs;

  localparam int unsigned ROM_ADDR_W = 15;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_e;

endpackage

// File: rtl/program_loader.sv
// Loads a framed, checksummed program image into instruction ROM and holds the
// CPU in reset until the image verifies.
module program_loader
  import program_loader_defs::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error
);

  state_e            state_q, state_d;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic [7:0]        sum_q;
  logic [7:0]        hi_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [15:0]       rom_wdata_q;

  logic        accept;
  logic [15:0] new_len;
  logic        too_long;
  logic        last_word;
  logic        reload;

  assign accept    = in_valid && in_ready;
  assign new_len   = {len_q[15:8], in_data};
  // Images may fill the ROM exactly; one word more cannot be addressed.
  assign too_long  = 32'(new_len) > (32'd1 << ADDR_W);
  assign last_word = (idx_q == len_q - 16'd1);
  assign reload    = ((state_q == RUN) || (state_q == ERROR)) && load_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (too_long)             state_d = ERROR;
          else if (new_len == '0)   state_d = CHECK;
          else                      state_d = DATA_HI;
        end
      end
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: if (accept) state_d = last_word ? CHECK : DATA_HI;
      CHECK:   if (accept) state_d = (in_data == sum_q) ? RUN : ERROR;
      RUN:     if (load_req) state_d = LEN_HI;
      ERROR:   if (load_req) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cpu_reset = 1'b1;
    error     = 1'b0;
    unique case (state_q)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      RUN:     cpu_reset = 1'b0;
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
    end else begin
      rom_we_q <= 1'b0;
      if (reload) begin
        len_q <= '0;
        idx_q <= '0;
        sum_q <= '0;
      end else if (accept) begin
        sum_q <= sum_q + in_data;
        unique case (state_q)
          LEN_HI:  len_q[15:8] <= in_data;
          LEN_LO:  len_q[7:0]  <= in_data;
          DATA_HI: hi_q        <= in_data;
          DATA_LO: begin
            rom_we_q    <= 1'b1;
            rom_addr_q  <= ADDR_W'(idx_q);
            rom_wdata_q <= {hi_q, in_data};
            idx_q       <= idx_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_req;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        error;

  int unsigned vectors;
  int unsigned miscompares;

  logic [14:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  program_loader #(.ADDR_W(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_req  (load_req),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rom_we) begin
      wr_addr_q.push_back(rom_addr);
      wr_data_q.push_back(rom_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic chk_good_writes(input string tag);
    chk({tag, "_cnt"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk({tag, "_a0"}, 32'(wr_addr_q[0]), 32'd0);
      chk({tag, "_d0"}, 32'(wr_data_q[0]), 32'h0005);
      chk({tag, "_a1"}, 32'(wr_addr_q[1]), 32'd1);
      chk({tag, "_d1"}, 32'(wr_data_q[1]), 32'hEC10);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    load_req    = 1'b0;

    // Reset values.
    #12;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Good two-word frame, no gaps.
    clear_log();
    send(8'h00); send(8'h02); send(8'h00); send(8'h05);
    chk("t1_we0", 32'(rom_we), 32'd1);
    chk("t1_addr0", 32'(rom_addr), 32'd0);
    chk("t1_data0", 32'(rom_wdata), 32'h0005);
    send(8'hEC);
    chk("t1_we_gap", 32'(rom_we), 32'd0);
    send(8'h10);
    chk("t1_we1", 32'(rom_we), 32'd1);
    chk("t1_addr1", 32'(rom_addr), 32'd1);
    chk("t1_data1", 32'(rom_wdata), 32'hEC10);
    chk("t1_cpu_reset_pre", 32'(cpu_reset), 32'd1);
    send(8'h03);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk_good_writes("t1_log");

    // Reload, then bad checksum.
    pulse_load_req();
    chk("t2_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_reload_busy", 32'(busy), 32'd1);
    send(8'h00); send(8'h02); send(8'h00); send(8'h05);
    send(8'hEC); send(8'h10); send(8'h04);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    chk("t2_error_sticky", 32'(error), 32'd1);
    pulse_load_req();
    chk("t2_error_clear", 32'(error), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    clear_log();
    send(8'h00); send(8'h02); send(8'h00); send(8'h05);
    send(8'hEC); send(8'h10); send(8'h03);
    chk("t2_boot", 32'(cpu_reset), 32'd0);
    chk_good_writes("t2_log");

    // Empty frame.
    pulse_load_req();
    clear_log();
    send(8'h00); send(8'h00);
    chk("t3_cpu_reset_pre", 32'(cpu_reset), 32'd1);
    send(8'h00);
    chk("t3_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t3_error", 32'(error), 32'd0);
    chk("t3_writes", 32'(wr_addr_q.size()), 32'd0);

    // Oversized length 0x8001.
    pulse_load_req();
    clear_log();
    send(8'h80); send(8'h01);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    send(8'h12); send(8'h34);
    chk("t4_writes", 32'(wr_addr_q.size()), 32'd0);

    // Async reset mid-frame after word 1's high byte.
    pulse_load_req();
    send(8'h00); send(8'h02); send(8'h00); send(8'h05); send(8'hEC);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_log();
    send(8'h00); send(8'h01); send(8'hAB); send(8'hCD);
    chk("t5_we", 32'(rom_we), 32'd1);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    chk("t5_data", 32'(rom_wdata), 32'hABCD);
    send(8'h79);
    chk("t5_boot", 32'(cpu_reset), 32'd0);

    // Gapped stream with an ignored load_req in DATA_LO.
    pulse_load_req();
    clear_log();
    send(8'h00); idle(2);
    send(8'h02); idle(1);
    send(8'h00);
    pulse_load_req();
    idle(2);
    chk("t6_busy", 32'(busy), 32'd1);
    send(8'h05); idle(3);
    send(8'hEC);
    send(8'h10); idle(1);
    send(8'h03);
    chk("t6_boot", 32'(cpu_reset), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk_good_writes("t6_log");

    // Byte offered with load_req in RUN is not taken.
    in_valid = 1'b1;
    in_data  = 8'h00;
    load_req = 1'b1;
    #1;
    chk("t7_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    load_req = 1'b0;
    in_valid = 1'b0;
    chk("t7_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t7_state_len_hi", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
